// File: rtl/lcd_bus_writer.sv
// Write-only 8-bit HD44780/KS0066 bus driver: one-time power-on init, then endless
// refresh of two 16-character lines, each frame taken from a snapshot of the inputs.
module lcd_bus_writer #(
    parameter logic [15:0] PWR_WAIT     = 16'd40000,
    parameter logic [7:0]  E_PULSE      = 8'd20,
    parameter logic [15:0] INS_WAIT     = 16'd1000,
    parameter logic [15:0] CLR_WAIT     = 16'd40000,
    parameter logic [15:0] DATA_WAIT    = 16'd1000,
    parameter logic [23:0] REFRESH_WAIT = 24'd2000000
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic [127:0] LineA,
    input  logic [127:0] LineB,
    output logic [7:0]   DB,
    output logic         RS,
    output logic         RW,
    output logic         E,
    output logic         init_done,
    output logic         frame_done
);

    typedef enum logic [2:0] {ST_PWR, ST_SETUP, ST_PULSE, ST_WAIT, ST_REFRESH} state_t;
    typedef enum logic [2:0] {
        S_FUNC, S_DISP, S_CLR, S_ENTRY, S_ADDR_A, S_DATA_A, S_ADDR_B, S_DATA_B
    } step_t;

    state_t         state;
    step_t          step;
    step_t          nb_step;
    logic [3:0]     idx;
    logic [3:0]     nb_idx;
    logic [23:0]    cnt;
    logic [23:0]    cnt_inc;
    logic [23:0]    wait_len;
    logic [127:0]   snap_a;
    logic [127:0]   snap_b;
    logic [7:0]     nb_db;
    logic           nb_rs;
    logic           to_refresh;
    logic           pulse_last;
    logic           byte_end;

    assign RW = 1'b0;

    always_comb begin
        cnt_inc = cnt + 24'd1;
        case (step)
            S_CLR:              wait_len = {8'd0, CLR_WAIT};
            S_DATA_A, S_DATA_B: wait_len = {8'd0, DATA_WAIT};
            default:            wait_len = {8'd0, INS_WAIT};
        endcase
        pulse_last = (cnt_inc >= {16'd0, E_PULSE});
        // A zero WAIT lets the byte finish straight out of PULSE.
        byte_end = ((state == ST_PULSE) && pulse_last && (wait_len == '0)) ||
                   ((state == ST_WAIT) && (cnt_inc >= wait_len));

        nb_step    = step;
        nb_idx     = '0;
        to_refresh = 1'b0;
        case (step)
            S_FUNC:   nb_step = S_DISP;
            S_DISP:   nb_step = S_CLR;
            S_CLR:    nb_step = S_ENTRY;
            S_ENTRY:  nb_step = S_ADDR_A;
            S_ADDR_A: nb_step = S_DATA_A;
            S_DATA_A: begin
                nb_idx = idx + 4'd1;
                if (idx == 4'd15) nb_step = S_ADDR_B;
            end
            S_ADDR_B: nb_step = S_DATA_B;
            S_DATA_B: begin
                nb_idx = idx + 4'd1;
                if (idx == 4'd15) begin
                    nb_step    = S_ADDR_A;
                    to_refresh = 1'b1;
                end
            end
            default:  nb_step = S_FUNC;
        endcase

        case (nb_step)
            S_FUNC:   nb_db = 8'h38;
            S_DISP:   nb_db = 8'h0C;
            S_CLR:    nb_db = 8'h01;
            S_ENTRY:  nb_db = 8'h06;
            S_ADDR_A: nb_db = 8'h80;
            S_DATA_A: nb_db = snap_a[{nb_idx, 3'b000} +: 8];
            S_ADDR_B: nb_db = 8'hC0;
            S_DATA_B: nb_db = snap_b[{nb_idx, 3'b000} +: 8];
            default:  nb_db = 8'h00;
        endcase
        nb_rs = (nb_step == S_DATA_A) || (nb_step == S_DATA_B);
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state      <= ST_PWR;
            step       <= S_FUNC;
            idx        <= '0;
            cnt        <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            DB         <= 8'h00;
            RS         <= 1'b0;
            E          <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (byte_end) begin
                E    <= 1'b0;
                cnt  <= '0;
                step <= nb_step;
                idx  <= nb_idx;
                if (step == S_ENTRY) init_done <= 1'b1;
                if (to_refresh) frame_done <= 1'b1;
                // RS/DB keep the last character through REFRESH.
                if (to_refresh && (REFRESH_WAIT != '0)) begin
                    state <= ST_REFRESH;
                end else begin
                    state <= ST_SETUP;
                    DB    <= nb_db;
                    RS    <= nb_rs;
                end
            end else begin
                case (state)
                    ST_PWR: begin
                        if (cnt_inc >= {8'd0, PWR_WAIT}) begin
                            state <= ST_SETUP;
                            cnt   <= '0;
                            DB    <= 8'h38;
                            RS    <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_SETUP: begin
                        if (step == S_ADDR_A) begin
                            snap_a <= LineA;
                            snap_b <= LineB;
                        end
                        E     <= 1'b1;
                        cnt   <= '0;
                        state <= ST_PULSE;
                    end
                    ST_PULSE: begin
                        if (pulse_last) begin
                            E     <= 1'b0;
                            cnt   <= '0;
                            state <= ST_WAIT;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_WAIT: cnt <= cnt_inc;
                    ST_REFRESH: begin
                        if (cnt_inc >= REFRESH_WAIT) begin
                            state <= ST_SETUP;
                            cnt   <= '0;
                            DB    <= 8'h80;
                            RS    <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= ST_PWR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: init table, modelled frame contents/timing, snapshot and reset cases.
module tb_lcd_bus_writer;

    localparam int PW  = 4;
    localparam int EP  = 2;
    localparam int INS = 3;
    localparam int CLR = 5;
    localparam int DW  = 2;
    localparam int RFW = 8;
    localparam int HIST = 1200;

    logic         mclk;
    logic         rst;
    logic [127:0] LineA;
    logic [127:0] LineB;
    logic [7:0]   DB;
    logic         RS;
    logic         RW;
    logic         E;
    logic         init_done;
    logic         frame_done;

    lcd_bus_writer #(
        .PWR_WAIT(16'(PW)), .E_PULSE(8'(EP)), .INS_WAIT(16'(INS)),
        .CLR_WAIT(16'(CLR)), .DATA_WAIT(16'(DW)), .REFRESH_WAIT(24'(RFW))
    ) dut (
        .mclk(mclk), .rst(rst), .LineA(LineA), .LineB(LineB),
        .DB(DB), .RS(RS), .RW(RW), .E(E),
        .init_done(init_done), .frame_done(frame_done)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: timeline of writes seen on the bus ----------------
    typedef struct {
        int       cyc;
        logic [7:0] db;
        logic     rs;
    } wr_t;

    wr_t          wq[$];
    int           fd_q[$];
    int           cyc = 0;
    int           init_rise = -1;
    int           hi_len = 0;
    int           early_e = 0;
    int           rw_bad = 0;
    bit           prev_e = 1'b0;
    bit           prev_init = 1'b0;
    logic [127:0] hist_a [0:HIST-1];
    logic [127:0] hist_b [0:HIST-1];

    always @(negedge mclk) begin
        if (!rst) begin
            cyc = 0; prev_e = 1'b0; prev_init = 1'b0; hi_len = 0; early_e = 0;
            init_rise = -1;
            wq.delete();
            fd_q.delete();
        end else begin
            if (cyc < HIST) begin
                hist_a[cyc] = LineA;
                hist_b[cyc] = LineB;
            end
            if (RW !== 1'b0) rw_bad++;
            if (E === 1'b1 && cyc < PW) early_e++;
            if (E === 1'b1 && !prev_e) wq.push_back('{cyc, DB, RS});
            if (E === 1'b1) hi_len++;
            else if (hi_len != 0) begin
                chk("e_high_len", hi_len, EP);
                hi_len = 0;
            end
            if (frame_done === 1'b1) fd_q.push_back(cyc);
            if (init_done === 1'b1 && !prev_init && init_rise < 0) init_rise = cyc;
            prev_e    = (E === 1'b1);
            prev_init = (init_done === 1'b1);
            cyc++;
        end
    end

    // ---------------- reference model (plain arithmetic over the write list) ----------------
    function automatic int wlen(input int k);
        return 1 + EP + ((k == 0 || k == 17) ? INS : DW);
    endfunction

    function automatic int offset(input int k);
        int s = 0;
        for (int j = 0; j < k; j++) s += wlen(j);
        return s;
    endfunction

    function automatic int frame_start(input int n);
        int init_len = 3 * (1 + EP + INS) + (1 + EP + CLR);
        return PW + init_len + n * (offset(34) + RFW);
    endfunction

    function automatic logic [8:0] exp_byte(input int k, input logic [127:0] a, input logic [127:0] b);
        if (k == 0)  return {1'b0, 8'h80};
        if (k <= 16) return {1'b1, a[(k-1)*8 +: 8]};
        if (k == 17) return {1'b0, 8'hC0};
        return {1'b1, b[(k-18)*8 +: 8]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    int now = 0;

    task automatic step_to(input int c);
        while (now < c) begin
            @(posedge mclk);
            #1;
            now++;
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] db;
        logic       rs;
    } init_vec_t;

    init_vec_t init_tbl [4];

    task automatic check_init();
        chk("init_count", (wq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("init%0d_cyc", i), wq[i].cyc, init_tbl[i].cyc);
                chk($sformatf("init%0d_db", i), wq[i].db, init_tbl[i].db);
                chk($sformatf("init%0d_rs", i), wq[i].rs, init_tbl[i].rs);
            end
        end
        chk("pwr_quiet", early_e, 0);
        chk("init_done_rise", init_rise, 30);
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        int           w;
        logic [8:0]   e;

        init_tbl[0] = '{5,  8'h38, 1'b0};
        init_tbl[1] = '{11, 8'h0C, 1'b0};
        init_tbl[2] = '{17, 8'h01, 1'b0};
        init_tbl[3] = '{25, 8'h06, 1'b0};

        rst = 1'b0; LineA = '0; LineB = '0;
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_E", E, 0);
        chk("rst_RS", RS, 0);
        chk("rst_RW", RW, 0);
        chk("rst_DB", DB, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_frame_done", frame_done, 0);

        a = {16{8'h41}};
        a[7:0] = 8'h53;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = (i < 10) ? 8'(8'h30 + i) : 8'h20;
        LineA = a;
        LineB = b;
        rst = 1'b1;
        now = 0;

        // change LineA while character 5 of frame 1 is on the bus
        step_to(frame_start(1) + offset(6) + 2);
        LineA = {16{8'h5A}};

        for (int f = 2; f <= 4; f++) begin
            step_to(frame_start(f) + int'($urandom_range(2, 90)));
            LineA = rnd128();
            LineB = rnd128();
            step_to(frame_start(f) + int'($urandom_range(91, 178)));
            LineA = rnd128();
            LineB = rnd128();
        end
        step_to(frame_start(4) + 176);

        check_init();
        chk("write_count", (wq.size() >= 4 + 5 * 34) ? 1 : 0, 1);
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 34; k++) begin
                w = 4 + 34 * n + k;
                if (w < wq.size()) begin
                    e = exp_byte(k, hist_a[frame_start(n)], hist_b[frame_start(n)]);
                    chk($sformatf("f%0d_w%0d_cyc", n, k), wq[w].cyc, frame_start(n) + offset(k) + 1);
                    chk($sformatf("f%0d_w%0d_rsdb", n, k), {wq[w].rs, wq[w].db}, e);
                end
            end
        end
        chk("fd_count", fd_q.size(), 5);
        for (int n = 0; n < 5 && n < fd_q.size(); n++)
            chk($sformatf("fd%0d_cyc", n), fd_q[n], frame_start(n) + offset(34));
        if (fd_q.size() >= 2) chk("fd_period", fd_q[1] - fd_q[0], 180);
        if (wq.size() >= 4 + 2 * 34 + 2) begin
            chk("snap_old_col0", wq[4 + 34 + 1].db, 8'h53);
            chk("snap_old_col5", wq[4 + 34 + 6].db, 8'h41);
            chk("snap_new_col0", wq[4 + 68 + 1].db, 8'h5A);
        end

        // reset during the first DATA_B pulse of frame 5, between clock edges
        step_to(frame_start(5) + offset(18) + 1);
        chk("pre_rst_E", E, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_E", E, 0);
        chk("mid_rst_DB", DB, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_RS", RS, 0);
        repeat (3) @(posedge mclk);
        #1;
        rst = 1'b1;
        now = 0;
        step_to(40);
        check_init();
        chk("rw_low", rw_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_writer.md
Name: lcd_bus_writer

Overview:
- Downstream stage of lcd_display_controller. Consumes its two 16-character line buffers and drives the parallel bus of a KS0066/HD44780-compatible 16x2 LCD. The bus is write-only and 8-bit.
- After reset, runs the power-on init sequence once, then refreshes both display lines forever.
- Each frame works from a snapshot of both lines, so the upstream block may update its buffers at any time.

Parameters:
- PWR_WAIT, 16'd40000: mclk cycles idle after reset release before the first instruction.
- E_PULSE, 8'd20: mclk cycles E is held high per write.
- INS_WAIT, 16'd1000: mclk cycles after E falls, for instructions other than clear.
- CLR_WAIT, 16'd40000: mclk cycles after E falls, for clear display (0x01).
- DATA_WAIT, 16'd1000: mclk cycles after E falls, for character writes.
- REFRESH_WAIT, 24'd2000000: mclk cycles idle between frames.

Ports:
- mclk, input, 1: main clock.
- rst, input, 1: reset. Asynchronous, active-low (0 = reset).
- LineA, input, 128: top line. Byte i = LineA[8i+:8] is column i; column 0 is leftmost.
- LineB, input, 128: bottom line, same byte mapping as LineA.
- DB, output, 8: LCD data bus.
- RS, output, 1: register select. 0 = instruction, 1 = data.
- RW, output, 1: read/write. Tied 0.
- E, output, 1: LCD enable strobe.
- init_done, output, 1: high from completion of the init sequence until the next reset.
- frame_done, output, 1: one-cycle pulse when the last character of LineB finishes its wait.

Behaviour:
- Reset (rst=0, asynchronous): E=0, RS=0, RW=0, DB=8'h00, init_done=0, frame_done=0. FSM goes to PWR; all counters clear.
- Reset asserted mid-write or mid-frame: E drops immediately, the current frame is abandoned, and the full init sequence reruns after release.
- Write transaction (shared by every byte), three phases:
  - SETUP: 1 cycle. RS and DB driven to their new values, E=0.
  - PULSE: E_PULSE cycles with E=1.
  - WAIT: W cycles with E=0, where W = CLR_WAIT, INS_WAIT or DATA_WAIT according to the byte.
  - RS and DB hold their values through PULSE and WAIT and change only at the next SETUP.
  - Total length = 1 + E_PULSE + W cycles.
- PWR: count PWR_WAIT cycles after reset release, then go to INIT.
- INIT: four instruction writes (RS=0), in order:
  - 0x38: function set, 8-bit, 2-line, 5x8.
  - 0x0C: display on, cursor off.
  - 0x01: clear; uses CLR_WAIT.
  - 0x06: entry mode, increment, no shift.
  - init_done rises in the cycle after the 0x06 WAIT completes; this is the same cycle as the first frame's SETUP.
- Frame sequence:
  - ADDR_A: instruction 0x80.
  - DATA_A: 16 data writes (RS=1), bytes sA[7:0] through sA[127:120] in column order.
  - ADDR_B: instruction 0xC0.
  - DATA_B: 16 data writes, bytes sB[7:0] through sB[127:120].
  - REFRESH: REFRESH_WAIT idle cycles with E=0, then back to ADDR_A.
- Snapshot: sA<=LineA and sB<=LineB are registered in the ADDR_A SETUP cycle. Input changes at any other time do not affect the frame in progress.
- frame_done: high for exactly the first cycle of REFRESH.
- Character index counter is 4 bits and wraps 15 to 0 at the ADDR_B transition and at frame end. It never indexes past byte 15.
- Frame period in steady state = 2*(1+E_PULSE+INS_WAIT) + 32*(1+E_PULSE+DATA_WAIT) + REFRESH_WAIT.
- Parameter rules:
  - A parameter value of 0 means zero cycles in that phase, with E_PULSE as the exception.
  - E_PULSE=0 is illegal; E_PULSE >= 1 is required.
- RW is constant 0 in every state; the writer never reads the LCD busy flag.

Test Plan:
- Bench parameters for all scenarios: PWR_WAIT=4, E_PULSE=2, INS_WAIT=3, CLR_WAIT=5, DATA_WAIT=2, REFRESH_WAIT=8.
- Init sequence:
  - Stimulus: release rst at cycle 0.
  - Required response: E stays low for cycles 0-3.
  - Four E pulses carry DB=38,0C,01,06 with RS=0.
  - Pulse spacing is 6, 6 and 8 cycles.
  - init_done rises at cycle 30.
- Frame content:
  - Stimulus: LineA={16{8'h41}} with byte0=8'h53; LineB=byte i = 8'h30+i (i=0..9), rest 8'h20.
  - Required response: E-captured sequence is 80, 53, 41x15, C0, 30..39, 20x6.
  - RS=0 only on 80 and C0.
  - frame_done pulses at cycle 30+172.
- Steady-state timing:
  - Stimulus: let the writer run two consecutive frames.
  - Required response: consecutive frame_done pulses are exactly 180 cycles apart.
  - E high time is always 2 cycles.
  - RW=0 throughout.
- Snapshot:
  - Stimulus: change LineA to all 8'h5A during DATA_A, char 5.
  - Required response: the current frame still shows the old bytes.
  - The next frame shows 5A x16.
- Mid-operation reset:
  - Stimulus: assert rst=0 during a PULSE phase of DATA_B.
  - Required response: E=0, DB=0 and init_done=0 in the same cycle, with no clock edge needed.
  - After release, the sequence restarts with a 4-cycle wait and then 0x38.
